// File: rtl/conv2_fc1_pkg.sv
// Shared constants and FSM state type for the conv2 -> fc1 bank reader.
package conv2_fc1_pkg;

  localparam int N_CH   = 16;  // channels (banks) per address
  localparam int DW     = 8;   // data width per channel
  localparam int AW     = 11;  // bank address width
  localparam int RD_LAT = 1;   // default port-B read latency (legal 1..3)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

endpackage

// File: rtl/fc1_beat_buffer.sv
// Two-deep word buffer that serialises one N_CH-channel bank word into
// N_CH beats of a valid/ready stream. out_buf is being streamed, stage_buf
// holds the next word so the stream continues with no bubble.
module fc1_beat_buffer #(
  parameter int N_CH = 16,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_valid,   // bank word present on cap_data this cycle
  input  logic              cap_last,    // word belongs to the final address
  input  logic [N_CH*DW-1:0] cap_data,
  input  logic              ready,
  output logic              valid,
  output logic [DW-1:0]     data,
  output logic              last,
  output logic [1:0]        full_cnt     // number of occupied word buffers
);

  localparam int            BW        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_CH - 1);

  logic [N_CH*DW-1:0] out_data;
  logic [N_CH*DW-1:0] stage_data;
  logic               out_full;
  logic               stage_full;
  logic               out_last;
  logic               stage_last;
  logic [BW-1:0]      beat_idx;
  logic               hs;
  logic               word_done;

  assign hs        = out_full & ready;
  assign word_done = hs & (beat_idx == LAST_BEAT);

  assign valid    = out_full;
  assign data     = out_data[beat_idx*DW +: DW];
  assign last     = out_full & out_last & (beat_idx == LAST_BEAT);
  assign full_cnt = {1'b0, out_full} + {1'b0, stage_full};

  // Beat pointer: advances only on a handshake, so data/last hold while stalled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
    end else if (hs) begin
      beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + BW'(1);
    end
  end

  // Capture and refill: a new word goes to out_buf when it is free (or frees
  // on this edge and stage_buf has nothing queued), otherwise to stage_buf.
  // NOTE: the word buffers are reset too, because data_in_fc1 is a direct
  // slice of out_buf and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      stage_data <= '0;
      out_full   <= 1'b0;
      stage_full <= 1'b0;
      out_last   <= 1'b0;
      stage_last <= 1'b0;
    end else if (word_done) begin
      if (stage_full) begin
        out_data <= stage_data;
        out_last <= stage_last;
        if (cap_valid) begin
          stage_data <= cap_data;
          stage_last <= cap_last;
        end else begin
          stage_full <= 1'b0;
        end
      end else if (cap_valid) begin
        out_data <= cap_data;
        out_last <= cap_last;
      end else begin
        out_full <= 1'b0;
      end
    end else if (cap_valid) begin
      if (!out_full) begin
        out_data <= cap_data;
        out_last <= cap_last;
        out_full <= 1'b1;
      end else begin
        stage_data <= cap_data;
        stage_last <= cap_last;
        stage_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv2_fc1_reader.sv
// Read side of the conv2 output banks: issues port-B reads in address order
// and flattens each N_CH-channel word into an address-major DW-bit stream
// for fc1, sustaining one beat per cycle.
module conv2_fc1_reader #(
  parameter int N_CH   = conv2_fc1_pkg::N_CH,
  parameter int DW     = conv2_fc1_pkg::DW,
  parameter int AW     = conv2_fc1_pkg::AW,
  parameter int RD_LAT = conv2_fc1_pkg::RD_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AW:0]        frame_len,
  output logic               enb2,
  output logic               web2,
  output logic [AW-1:0]      addrb2,
  input  logic [N_CH*DW-1:0] datain2_flat,
  output logic [DW-1:0]      data_in_fc1,
  output logic               fc1_valid,
  input  logic               fc1_ready,
  output logic               fc1_last,
  output logic               busy,
  output logic               done
);

  import conv2_fc1_pkg::*;

  localparam logic [AW:0] LEN_ONE = (AW + 1)'(1);

  state_t            state;
  logic [AW:0]       len_q;       // latched frame length
  logic [AW:0]       next_addr;   // next address to read (also reads issued)
  logic              rd_last_q;   // read currently on enb2 is the final address
  logic [RD_LAT-1:0] pipe_vld;    // read tags travelling with bank latency
  logic [RD_LAT-1:0] pipe_last;
  logic              cap_valid;
  logic              cap_last;
  logic [1:0]        full_cnt;
  logic              in_flight;
  logic              issue;
  logic              final_hs;

  assign web2      = 1'b0;
  assign cap_valid = pipe_vld[RD_LAT-1];
  assign cap_last  = pipe_last[RD_LAT-1];
  assign in_flight = enb2 | (|pipe_vld);
  // One read in flight at most, and only when its word has a free buffer.
  assign issue     = (state == RUN) && (next_addr < len_q) && !in_flight &&
                     (full_cnt <= 2'd1);
  assign final_hs  = fc1_valid & fc1_ready & fc1_last;

  // Frame control: latches the request, issues reads, signals busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      next_addr <= '0;
      rd_last_q <= 1'b0;
      enb2      <= 1'b0;
      addrb2    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      enb2 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= frame_len;
            busy  <= 1'b1;
            if (frame_len == '0) begin
              next_addr <= '0;
              state     <= ZERO;
            end else begin
              // First read goes out straight away to meet the start latency.
              enb2      <= 1'b1;
              addrb2    <= '0;
              next_addr <= LEN_ONE;
              rd_last_q <= (frame_len == LEN_ONE);
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            enb2      <= 1'b1;
            addrb2    <= next_addr[AW-1:0];
            next_addr <= next_addr + LEN_ONE;
            rd_last_q <= (next_addr == len_q - LEN_ONE);
          end
          if (final_hs) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        ZERO: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-tag pipe: marks the cycle in which bank data for a read is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= enb2;
      pipe_last[0] <= rd_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  fc1_beat_buffer #(
    .N_CH (N_CH),
    .DW   (DW)
  ) u_beat_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_valid (cap_valid),
    .cap_last  (cap_last),
    .cap_data  (datain2_flat),
    .ready     (fc1_ready),
    .valid     (fc1_valid),
    .data      (data_in_fc1),
    .last      (fc1_last),
    .full_cnt  (full_cnt)
  );

endmodule
